// File: rtl/mux_pkg.sv
// Shared constants and helpers for the round-robin / selector output multiplexer.
package mux_pkg;

    localparam logic MODE_SEL = 1'b0;
    localparam logic MODE_RR  = 1'b1;

    // Index width that stays at least one bit wide even for two channels.
    function automatic int clog2_min1(input int n);
        if (n <= 2) begin
            return 1;
        end else begin
            return $clog2(n);
        end
    endfunction

endpackage

// File: rtl/mux_rr_param_rr_arbiter.sv
// Rotating-priority arbiter: the first requester after last_grant wins, wrapping at NCH.
module rr_arbiter
    import mux_pkg::*;
#(
    parameter int NCH = 4,
    parameter int SW  = clog2_min1(NCH)
) (
    input  logic [NCH-1:0] req,
    input  logic [SW-1:0]  last_grant,
    input  logic           en,
    output logic           gnt_valid,
    output logic [SW-1:0]  gnt_idx
);

    function automatic logic [SW-1:0] wrap_idx(input logic [SW-1:0] base, input int off);
        return SW'((int'(base) + off) % NCH);
    endfunction

    // Scan farthest offset first so the nearest requester after last_grant overrides.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        for (int k = NCH; k >= 1; k--) begin
            if (en && req[wrap_idx(last_grant, k)]) begin
                gnt_valid = 1'b1;
                gnt_idx   = wrap_idx(last_grant, k);
            end else begin
                gnt_valid = gnt_valid;
                gnt_idx   = gnt_idx;
            end
        end
    end

endmodule

// File: rtl/mux_rr_param.sv
// N-to-1 registered valid/ready multiplexer with selector or round-robin channel choice
// and a wrapping count of words accepted downstream.
module mux_rr_param
    import mux_pkg::*;
#(
    parameter int NCH   = 4,
    parameter int W     = 2,
    parameter int CNT_W = 6,
    parameter int SW    = clog2_min1(NCH)
) (
    input  logic             clk,
    input  logic             reset_L,
    input  logic             mode,
    input  logic [SW-1:0]    selector,
    input  logic [NCH*W-1:0] data_in,
    input  logic [NCH-1:0]   valid_in,
    output logic [NCH-1:0]   ready_out,
    output logic [W-1:0]     data_out,
    output logic             valid_out,
    input  logic             ready_in,
    output logic [SW-1:0]    grant_id,
    output logic [CNT_W-1:0] contador
);

    logic [W-1:0]     r_data_out;
    logic             r_valid_out;
    logic [SW-1:0]    r_grant_id;
    logic [CNT_W-1:0] r_contador;
    logic [SW-1:0]    r_last_grant;

    logic             w_load_en;
    logic             w_sel_valid;
    logic             w_rr_valid;
    logic [SW-1:0]    w_rr_idx;
    logic             w_grant;
    logic [SW-1:0]    w_chosen;
    logic [W-1:0]     w_data;

    assign w_load_en = !r_valid_out || ready_in;

    rr_arbiter #(
        .NCH (NCH),
        .SW  (SW)
    ) u_rr_arbiter (
        .req        (valid_in),
        .last_grant (r_last_grant),
        .en         (mode == MODE_RR),
        .gnt_valid  (w_rr_valid),
        .gnt_idx    (w_rr_idx)
    );

    // Selector path: a selector beyond the last channel never grants.
    always_comb begin
        w_sel_valid = 1'b0;
        if (int'(selector) < NCH) begin
            w_sel_valid = valid_in[selector];
        end else begin
            w_sel_valid = 1'b0;
        end
    end

    // Mode steering between the selector path and the arbiter result.
    always_comb begin
        w_grant  = 1'b0;
        w_chosen = '0;
        case (mode)
            MODE_SEL: begin
                w_grant  = w_sel_valid;
                w_chosen = selector;
            end
            MODE_RR: begin
                w_grant  = w_rr_valid;
                w_chosen = w_rr_idx;
            end
            default: begin
                w_grant  = 1'b0;
                w_chosen = '0;
            end
        endcase
    end

    // One-hot accept and data pick for the chosen channel; ready is held low during reset.
    always_comb begin
        ready_out = '0;
        w_data    = '0;
        for (int i = 0; i < NCH; i++) begin
            ready_out[i] = reset_L && w_load_en && w_grant && (w_chosen == SW'(i));
            if (w_chosen == SW'(i)) begin
                w_data = data_in[i*W +: W];
            end else begin
                w_data = w_data;
            end
        end
    end

    // Output register, fairness pointer and accepted-word counter.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            r_data_out   <= '0;
            r_valid_out  <= 1'b0;
            r_grant_id   <= '0;
            r_contador   <= '0;
            r_last_grant <= SW'(NCH - 1);
        end else begin
            if (w_load_en) begin
                if (w_grant) begin
                    r_data_out   <= w_data;
                    r_grant_id   <= w_chosen;
                    r_valid_out  <= 1'b1;
                    r_last_grant <= w_chosen;
                end else begin
                    r_valid_out  <= 1'b0;
                end
            end
            if (r_valid_out && ready_in) begin
                r_contador <= r_contador + CNT_W'(1);
            end
        end
    end

    assign data_out  = r_data_out;
    assign valid_out = r_valid_out;
    assign grant_id  = r_grant_id;
    assign contador  = r_contador;

endmodule

// File: tb/tb_mux_rr_param.sv
// Directed bench for mux_rr_param (NCH=4, W=2, CNT_W=6) with hand-computed expectations.
module tb_mux_rr_param;

    logic       clk = 1'b0;
    logic       reset_L;
    logic       mode;
    logic [1:0] selector;
    logic [7:0] data_in;
    logic [3:0] valid_in;
    logic [3:0] ready_out;
    logic [1:0] data_out;
    logic       valid_out;
    logic       ready_in;
    logic [1:0] grant_id;
    logic [5:0] contador;

    int n_checks = 0;
    int n_fail   = 0;

    mux_rr_param #(.NCH(4), .W(2), .CNT_W(6)) dut (
        .clk       (clk),
        .reset_L   (reset_L),
        .mode      (mode),
        .selector  (selector),
        .data_in   (data_in),
        .valid_in  (valid_in),
        .ready_out (ready_out),
        .data_out  (data_out),
        .valid_out (valid_out),
        .ready_in  (ready_in),
        .grant_id  (grant_id),
        .contador  (contador)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_L  = 1'b0;
        mode     = 1'b1;
        selector = 2'd0;
        data_in  = 8'h00;
        valid_in = 4'b1111;
        ready_in = 1'b1;
        tick();
        tick();
        chk("rst_valid_out", 32'(valid_out), 32'd0);
        chk("rst_data_out",  32'(data_out),  32'd0);
        chk("rst_grant_id",  32'(grant_id),  32'd0);
        chk("rst_contador",  32'(contador),  32'd0);
        chk("rst_ready_out", 32'(ready_out), 32'd0);

        // 1: selector mode, ch0=10 ch1=11
        reset_L  = 1'b1;
        mode     = 1'b0;
        selector = 2'd1;
        data_in  = 8'b00_00_11_10;
        #1;
        chk("t1_ready_pre", 32'(ready_out), 32'b0010);
        tick();
        chk("t1_data",     32'(data_out),  32'd3);
        chk("t1_gid",      32'(grant_id),  32'd1);
        chk("t1_valid",    32'(valid_out), 32'd1);
        chk("t1_ready",    32'(ready_out), 32'b0010);
        chk("t1_cnt0",     32'(contador),  32'd0);
        tick();
        chk("t1_cnt1",     32'(contador),  32'd1);

        // 2: park pointer on ch3 via selector, then round-robin 0,1,2,3,0
        data_in  = 8'b11_10_01_00;
        selector = 2'd3;
        tick();
        chk("t2_park_gid", 32'(grant_id), 32'd3);
        chk("t2_park_cnt", 32'(contador), 32'd2);
        mode = 1'b1;
        tick(); chk("t2_d0", 32'(data_out), 32'd0); chk("t2_g0", 32'(grant_id), 32'd0);
        tick(); chk("t2_d1", 32'(data_out), 32'd1); chk("t2_g1", 32'(grant_id), 32'd1);
        tick(); chk("t2_d2", 32'(data_out), 32'd2); chk("t2_g2", 32'(grant_id), 32'd2);
        tick(); chk("t2_d3", 32'(data_out), 32'd3); chk("t2_g3", 32'(grant_id), 32'd3);
        tick(); chk("t2_d4", 32'(data_out), 32'd0); chk("t2_g4", 32'(grant_id), 32'd0);
        chk("t2_cnt", 32'(contador), 32'd7);

        // 3: backpressure holds ch0 word
        ready_in = 1'b0;
        #1;
        chk("t3_ready_stall", 32'(ready_out), 32'b0000);
        tick();
        tick();
        chk("t3_valid", 32'(valid_out), 32'd1);
        chk("t3_data",  32'(data_out),  32'd0);
        chk("t3_gid",   32'(grant_id),  32'd0);
        chk("t3_cnt",   32'(contador),  32'd7);
        chk("t3_ready", 32'(ready_out), 32'b0000);
        ready_in = 1'b1;
        #1;
        chk("t3_ready_go", 32'(ready_out), 32'b0010);
        tick();
        chk("t3_cnt_go",  32'(contador), 32'd8);
        chk("t3_data_go", 32'(data_out), 32'd1);
        chk("t3_gid_go",  32'(grant_id), 32'd1);

        // 4: sparse requests alternate 3,0,3
        valid_in = 4'b1001;
        tick(); chk("t4_g0", 32'(grant_id), 32'd3); chk("t4_d0", 32'(data_out), 32'd3);
        tick(); chk("t4_g1", 32'(grant_id), 32'd0); chk("t4_d1", 32'(data_out), 32'd0);
        tick(); chk("t4_g2", 32'(grant_id), 32'd3); chk("t4_d2", 32'(data_out), 32'd3);
        chk("t4_cnt", 32'(contador), 32'd11);
        // selector on a channel that is not valid
        mode     = 1'b0;
        selector = 2'd2;
        valid_in = 4'b1011;
        #1;
        chk("t4_inv_ready", 32'(ready_out), 32'b0000);
        tick();
        chk("t4_inv_valid", 32'(valid_out), 32'd0);
        chk("t4_inv_data",  32'(data_out),  32'd3);
        chk("t4_inv_gid",   32'(grant_id),  32'd3);
        chk("t4_inv_cnt",   32'(contador),  32'd12);
        tick();
        chk("t4_idle_cnt",  32'(contador),  32'd12);
        chk("t4_idle_rdy",  32'(ready_out), 32'b0000);

        // 5: counter wrap; pointer sits at 3 so loads run 0,1,2,3,...
        mode     = 1'b1;
        valid_in = 4'b1111;
        tick();
        chk("t5_first_gid", 32'(grant_id), 32'd0);
        chk("t5_first_cnt", 32'(contador), 32'd12);
        for (int i = 1; i <= 51; i++) begin
            tick();
            chk("t5_valid", 32'(valid_out), 32'd1);
            chk("t5_gid",   32'(grant_id),  32'(i % 4));
            chk("t5_data",  32'(data_out),  32'(i % 4));
        end
        chk("t5_cnt63", 32'(contador), 32'd63);
        tick();
        chk("t5_cnt0",  32'(contador), 32'd0);
        chk("t5_gid52", 32'(grant_id), 32'd0);
        tick();
        chk("t5_pre_rst_gid", 32'(grant_id), 32'd1);

        // 6: asynchronous reset between edges
        #2;
        reset_L = 1'b0;
        #1;
        chk("t6_valid", 32'(valid_out), 32'd0);
        chk("t6_data",  32'(data_out),  32'd0);
        chk("t6_gid",   32'(grant_id),  32'd0);
        chk("t6_cnt",   32'(contador),  32'd0);
        chk("t6_ready", 32'(ready_out), 32'b0000);
        tick();
        reset_L = 1'b1;
        #1;
        chk("t6_ready_rel", 32'(ready_out), 32'b0001);
        tick();
        chk("t6_first_gid",   32'(grant_id),  32'd0);
        chk("t6_first_valid", 32'(valid_out), 32'd1);
        chk("t6_first_cnt",   32'(contador),  32'd0);
        tick();
        chk("t6_second_gid",  32'(grant_id),  32'd1);
        chk("t6_second_cnt",  32'(contador),  32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mux_rr_param.md
Name: mux_rr_param

Overview:
- Parametrised N-to-1 registered multiplexer with valid/ready handshaking. It generalises the 2-channel, 2-bit selector mux.
- Two modes:
  - external-selector mode.
  - round-robin arbitration across channels.
- One output register stage.
- Built-in wrapping counter of accepted output words, for bench and debug use.
- Sits between N producer channels and a single downstream consumer in the datapath.

Parameters:
- NCH, 4, number of input channels (>=2; need not be a power of 2)
- W, 2, data width per channel
- CNT_W, 6, width of the accepted-word counter
- SW, derived = max(1, clog2(NCH)), width of the selector and grant_id ports

Ports:
- clk  in  1  single clock, all state updates on its rising edge
- reset_L  in  1  asynchronous active-low reset
- mode  in  1  0 = selector mode, 1 = round-robin mode
- selector  in  SW  channel to forward in selector mode
- data_in  in  NCH*W  channel i occupies bits [i*W +: W]
- valid_in  in  NCH  per-channel data valid
- ready_out  out  NCH  per-channel accept; combinational
- data_out  out  W  registered output data
- valid_out  out  1  registered output valid
- ready_in  in  1  downstream ready
- grant_id  out  SW  channel index of the word currently in the output register
- contador  out  CNT_W  count of words accepted downstream

Behaviour:
- Reset (asynchronous, reset_L=0):
  - data_out=0, valid_out=0, grant_id=0, contador=0.
  - Round-robin pointer last_grant=NCH-1, so channel 0 has first priority.
  - ready_out=0 while reset_L=0.
- Load enable: load_en = !valid_out || ready_in. This gives full throughput with no bubble.
- Channel choice, selector mode:
  - chosen = selector.
  - A grant exists iff selector < NCH and valid_in[selector]=1.
  - An out-of-range selector never grants.
- Channel choice, round-robin mode:
  - Search from (last_grant+1) mod NCH upward, wrapping; chosen = first i with valid_in[i]=1.
  - A grant exists iff any valid_in bit is 1.
- Handshake:
  - ready_out[i] = load_en && grant && (chosen==i). At most one bit is high.
  - Input transfer on channel i when valid_in[i] && ready_out[i].
- On a rising edge with load_en=1:
  - If grant: data_out <= data_in[chosen], grant_id <= chosen, valid_out <= 1.
  - If no grant: valid_out <= 0; data_out and grant_id hold.
- On a rising edge with load_en=0: data_out, valid_out and grant_id hold. Data is stable while stalled.
- last_grant update:
  - Updates to chosen on every input transfer, in either mode. This keeps fairness continuous across mode switches.
  - Otherwise holds.
- Latency: one cycle from input transfer to valid_out.
- Throughput: one word per cycle when ready_in=1.
- contador increments by 1 on each edge with valid_out && ready_in. It wraps 2^CNT_W-1 -> 0.
- mode and selector are sampled combinationally each cycle. A change affects the next load only; the word already in the output register is unaffected.
- Reset mid-operation:
  - A word held in the output register is discarded; valid_out drops immediately.
  - The counter and pointer reinitialise.
- Simultaneous downstream accept and new load in the same edge: the counter increments and the register loads the new word; both happen.

Decomposition:
- Shared package mux_pkg:
  - mode constants MODE_SEL=1'b0 and MODE_RR=1'b1.
  - function clog2_min1 for SW.
- One sub-module: rr_arbiter.
  - Parameter NCH.
  - Inputs: req[NCH], last_grant, en.
  - Outputs: gnt_valid, gnt_idx; rotate-and-priority-encode logic.
  - Instantiated once; the selector path is muxed around it in the top.

Test Plan (NCH=4, W=2, CNT_W=6):
1. Reset then selector mode:
   - Stimulus: reset_L low 2 cycles, then high; mode=0, selector=1, data_in ch0=10 ch1=11, all valid, ready_in=1.
   - Required: next edge data_out=11, grant_id=1, valid_out=1; ready_out=0010 each cycle; contador=1 after the following edge.
2. Round-robin fairness:
   - Stimulus: mode=1, valid_in=1111, data ch0..3 = 00,01,10,11, ready_in=1.
   - Required: data_out sequence 00,01,10,11,00 on consecutive cycles; grant_id 0,1,2,3,0.
3. Backpressure:
   - Stimulus: mode=1, ready_in=0 after the first load.
   - Required: valid_out stays 1, data_out and grant_id are frozen, ready_out=0000, contador does not change.
   - Then ready_in=1: the held word is counted and the next channel is loaded in the same edge.
4. Sparse requests and invalid selector:
   - Stimulus: mode=1, valid_in=1001.
   - Required: grants alternate 0,3,0,3.
   - Stimulus: mode=0, selector=2, valid_in[2]=0.
   - Required: valid_out=0 on the next edge and ready_out=0000.
5. Counter wrap:
   - Stimulus: 64 consecutive downstream accepts.
   - Required: contador goes 63 then 0; no other output glitch.
6. Asynchronous reset mid-stream:
   - Stimulus: assert reset_L=0 between clock edges while valid_out=1.
   - Required: valid_out, data_out, grant_id and contador are 0 immediately, without waiting for a clock edge.
   - After release: the first round-robin grant goes to channel 0.
